// File: rtl/serial_subtractor.sv
// Chunk-serial add/subtract: CHUNK bits per cycle LSB-first, WIDTH/CHUNK cycles per operation.
// Latency: DONE in the cycle after e0+N; START is ignored while BUSY and accepted in IDLE or FIN.
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CHUNK = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Z,
    output logic             V,
    output logic             BUSY,
    output logic             DONE
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_d;
    logic             r_mode, r_cy, r_bout, r_z, r_v;
    logic [IW-1:0]    r_idx;

    logic             w_load, w_step, w_last, w_v;
    logic [CHUNK-1:0] w_ak, w_bk;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    int               w_sh;

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            S_IDLE: if (START) begin
                w_load = 1'b1;
                w_next = S_RUN;
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) w_next = S_FIN;
            end
            S_FIN: begin
                if (START) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // One chunk of the borrow/carry chain; the wrapped top bit is the borrow in subtract mode.
    always_comb begin
        w_sh   = int'(r_idx) * CHUNK;
        w_last = (r_idx == IW'(N - 1));
        w_ak   = CHUNK'(r_a >> w_sh);
        w_bk   = CHUNK'(r_b >> w_sh);
        if (r_mode)
            w_sum = {1'b0, w_ak} - {1'b0, w_bk} - {{CHUNK{1'b0}}, r_cy};
        else
            w_sum = {1'b0, w_ak} + {1'b0, w_bk} + {{CHUNK{1'b0}}, r_cy};
        w_res = (r_res & ~(CMASK << w_sh)) | (WIDTH'(w_sum[CHUNK-1:0]) << w_sh);
        if (r_mode)
            w_v = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
        else
            w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_mode  <= 1'b0;
            r_cy    <= 1'b0;
            r_idx   <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_z     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_a    <= A;
                r_b    <= B;
                r_mode <= MODE;
                r_res  <= '0;
                r_cy   <= 1'b0;
                r_idx  <= '0;
            end else if (w_step) begin
                r_res <= w_res;
                r_cy  <= w_sum[CHUNK];
                r_idx <= r_idx + IW'(1);
                if (w_last) begin
                    r_d    <= w_res;
                    r_bout <= w_sum[CHUNK];
                    r_z    <= (w_res == '0);
                    r_v    <= w_v;
                end
            end
        end
    end

    assign D    = r_d;
    assign Bout = r_bout;
    assign Z    = r_z;
    assign V    = r_v;
    assign BUSY = (r_state == S_RUN);
    assign DONE = (r_state == S_FIN);
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a 4/1 instance driven from a vector table, plus 8/2 and 8/8 corner sequences.
module tb_serial_subtractor;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       mode = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;
    logic [2:0] start_v = '0;

    logic [3:0] d0;
    logic [7:0] d1, d2;
    logic [2:0] bo_v, z_v, v_v, busy_v, done_v;

    int         cur = 0;
    logic [7:0] m_d;
    logic       m_bo, m_z, m_v, m_busy, m_done;

    int tests = 0, fails = 0;

    always #5 CLK = ~CLK;

    serial_subtractor #(.WIDTH(4), .CHUNK(1)) u0 (
        .CLK(CLK), .RST(RST), .START(start_v[0]), .MODE(mode), .A(a_in[3:0]), .B(b_in[3:0]),
        .D(d0), .Bout(bo_v[0]), .Z(z_v[0]), .V(v_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0]));
    serial_subtractor #(.WIDTH(8), .CHUNK(2)) u1 (
        .CLK(CLK), .RST(RST), .START(start_v[1]), .MODE(mode), .A(a_in), .B(b_in),
        .D(d1), .Bout(bo_v[1]), .Z(z_v[1]), .V(v_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1]));
    serial_subtractor #(.WIDTH(8), .CHUNK(8)) u2 (
        .CLK(CLK), .RST(RST), .START(start_v[2]), .MODE(mode), .A(a_in), .B(b_in),
        .D(d2), .Bout(bo_v[2]), .Z(z_v[2]), .V(v_v[2]), .BUSY(busy_v[2]), .DONE(done_v[2]));

    always_comb begin
        case (cur)
            1:       m_d = d1;
            2:       m_d = d2;
            default: m_d = {4'b0, d0};
        endcase
        m_bo   = bo_v[cur];
        m_z    = z_v[cur];
        m_v    = v_v[cur];
        m_busy = busy_v[cur];
        m_done = done_v[cur];
    end

    typedef struct {
        logic       m;
        logic [3:0] a, b, d;
        logic       bo, z, v;
    } vec_t;
    vec_t tv[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Present operands, clock the START edge (e0), then scramble inputs to prove they were latched.
    task automatic start_op(input int sel, input logic m, input logic [7:0] a, input logic [7:0] b);
        cur = sel;
        mode = m;
        a_in = a;
        b_in = b;
        start_v = '0;
        start_v[sel] = 1'b1;
        @(posedge CLK);
        #1;
        start_v = '0;
        mode = ~m;
        a_in = ~a;
        b_in = ~b;
    endtask

    // Optionally pulses START while busy (on edges e2 and e3) to check it is ignored.
    task automatic wait_done(input int pulse, output int lat, output int busy);
        lat = 0;
        busy = 0;
        while (!m_done && lat < 20) begin
            if (m_busy) busy++;
            if (pulse >= 0) start_v[pulse] = (lat == 1 || lat == 2);
            @(posedge CLK);
            #1;
            lat++;
        end
        start_v = '0;
        if (lat >= 20) check("done_timeout", 32'(lat), 32'd0);
    endtask

    task automatic check_res(input string nm, input logic [7:0] d, input logic bo, input logic z, input logic v);
        check({nm, "_D"}, 32'(m_d), 32'(d));
        check({nm, "_Bout"}, 32'(m_bo), 32'(bo));
        check({nm, "_Z"}, 32'(m_z), 32'(z));
        check({nm, "_V"}, 32'(m_v), 32'(v));
        check({nm, "_busy_in_fin"}, 32'(m_busy), 32'd0);
    endtask

    int lat, busy, ndone;
    logic [7:0] d_hold;

    initial begin
        tv[0] = '{1'b1, 4'b0001, 4'b0011, 4'b1110, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b1, 4'b0100, 4'b1100, 4'b1000, 1'b1, 1'b0, 1'b1};
        tv[2] = '{1'b1, 4'b1101, 4'b0110, 4'b0111, 1'b0, 1'b0, 1'b1};
        tv[3] = '{1'b1, 4'b1010, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b1};
        tv[4] = '{1'b1, 4'b1000, 4'b1001, 4'b1111, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 4'b1001, 4'b0111, 4'b0000, 1'b1, 1'b1, 1'b0};
        tv[6] = '{1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1};
        tv[7] = '{1'b0, 4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0};
        tv[8] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge CLK);
        #1;
        for (int s = 0; s < 3; s++) begin
            cur = s;
            #1;
            check($sformatf("reset%0d", s), {m_d, m_bo, m_z, m_v, m_busy, m_done}, 32'd0);
        end
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 9; i++) begin
            start_op(0, tv[i].m, {4'b0, tv[i].a}, {4'b0, tv[i].b});
            wait_done(-1, lat, busy);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("v%0d_busy_cycles", i), 32'(busy), 32'd4);
            check_res($sformatf("v%0d", i), {4'b0, tv[i].d}, tv[i].bo, tv[i].z, tv[i].v);
            @(posedge CLK);
            #1;
            check($sformatf("v%0d_done_pulse", i), 32'(m_done), 32'd0);
            check($sformatf("v%0d_D_hold", i), 32'(m_d), 32'(tv[i].d));
        end

        // Back-to-back: START presented during the FIN cycle is taken at once.
        start_op(0, 1'b0, 8'h09, 8'h07);
        wait_done(-1, lat, busy);
        check_res("b2b_add", 8'h00, 1'b1, 1'b1, 1'b0);
        start_op(0, 1'b1, 8'h06, 8'h06);
        check("b2b_accepted", 32'(m_busy), 32'd1);
        wait_done(-1, lat, busy);
        check("b2b_latency", 32'(lat), 32'd4);
        check_res("b2b_sub", 8'h00, 1'b0, 1'b1, 1'b0);
        @(posedge CLK);
        #1;

        // 8-bit, 2 bits per cycle, with START pulses while busy.
        start_op(1, 1'b1, 8'h35, 8'h47);
        wait_done(1, lat, busy);
        check("w8c2_latency", 32'(lat), 32'd4);
        check_res("w8c2", 8'hEE, 1'b1, 1'b0, 1'b0);
        d_hold = m_d;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK);
            #1;
            if (m_done || m_busy) ndone++;
        end
        check("w8c2_single_done", 32'(ndone), 32'd0);
        check("w8c2_D_hold", 32'(m_d), 32'(d_hold));

        // 8-bit single-cycle configuration.
        start_op(2, 1'b1, 8'h80, 8'h01);
        wait_done(-1, lat, busy);
        check("w8c8_latency", 32'(lat), 32'd1);
        check("w8c8_busy_cycles", 32'(busy), 32'd1);
        check_res("w8c8", 8'h7F, 1'b0, 1'b0, 1'b1);
        @(posedge CLK);
        #1;

        // Reset in the second RUN cycle aborts the operation.
        start_op(0, 1'b1, 8'h01, 8'h03);
        wait_done(-1, lat, busy);
        check_res("pre_abort", 8'h0E, 1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        start_op(0, 1'b1, 8'h05, 8'h01);
        @(posedge CLK);
        #1;
        check("abort_busy_before", 32'(m_busy), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort_outputs", {m_d, m_bo, m_z, m_v, m_busy, m_done}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK);
            #1;
            if (m_done || m_busy) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        start_op(0, 1'b1, 8'h07, 8'h03);
        wait_done(-1, lat, busy);
        check("post_abort_latency", 32'(lat), 32'd4);
        check_res("post_abort", 8'h04, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational subtractor.
- Computes A−B (or A+B in add mode) over WIDTH/CHUNK clock cycles, processing CHUNK bits per cycle LSB-first with a registered borrow/carry chain.
- Uses a START/BUSY/DONE handshake and flags borrow, zero and signed overflow.
- Sits in the datapath wherever a narrow, area-cheap arithmetic unit is preferred over a full-width ripple array.

Parameters:
WIDTH, 4, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 1, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH
N (localparam), WIDTH/CHUNK, cycles per operation

Ports:
CLK    input   1      single clock, rising edge
RST    input   1      synchronous, active-high reset
START  input   1      request; sampled only when not BUSY
MODE   input   1      1 = subtract (A−B), 0 = add (A+B); latched with START
A      input   WIDTH  minuend/augend; latched with START
B      input   WIDTH  subtrahend/addend; latched with START
D      output  WIDTH  result, registered, held until next completion
Bout   output  1      sub: final borrow (1 iff A<B unsigned); add: carry-out
Z      output  1      1 iff D == 0
V      output  1      signed two's-complement overflow of the latched operation
BUSY   output  1      1 while an operation is in progress
DONE   output  1      one-cycle pulse when D/Bout/Z/V update

Behaviour:
- Reset: synchronous, active-high.
  - RST high at an edge: state IDLE; D=0, Bout=0, Z=0, V=0, BUSY=0, DONE=0.
  - Internal operand registers, chunk index and borrow cleared.
  - RST during RUN aborts the operation: no DONE, outputs go to reset values.
- States: IDLE, RUN, FIN.
- IDLE:
  - BUSY=0, DONE=0.
  - START=1 at edge e0: latch A, B, MODE; index=0; borrow/carry=0; go to RUN.
- RUN:
  - BUSY=1.
  - At each edge e1..eN, process chunk index k (bits k*CHUNK+CHUNK−1 : k*CHUNK):
    - sub: {b_out, r} = A_k − B_k − b_in
    - add: {c_out, r} = A_k + B_k + c_in
  - Write r into the internal result register and register b_out/c_out for the next chunk.
  - START is ignored in RUN.
  - After chunk N−1 (edge eN): load D from the full result, Bout = final borrow/carry, Z = (result==0).
  - V on the same edge:
    - sub: A[W−1]≠B[W−1] && D[W−1]≠A[W−1]
    - add: A[W−1]==B[W−1] && D[W−1]≠A[W−1]
  - Go to FIN.
- FIN:
  - DONE=1 and BUSY=0 for exactly one cycle.
  - START=1 at this edge is accepted (back-to-back), going to RUN as from IDLE; otherwise go to IDLE.
- Latency: DONE is high in the cycle after edge e0+N. For WIDTH=4, CHUNK=1 that is 4 cycles; for CHUNK=WIDTH, 1 cycle.
- Throughput: one operation every N+1 cycles.
- D/Bout/Z/V change only on a completing edge or reset; they hold otherwise.
- Input changes on A/B/MODE after the START edge have no effect on the running operation.
- Arithmetic is unsigned modulo 2^WIDTH. No sign extension; V is informational only.

Test Plan:
- WIDTH=4, CHUNK=1, sub, START with A=0001, B=0011 -> after 4 cycles DONE pulse: D=1110, Bout=1, Z=0, V=0; BUSY high 4 cycles.
- Sub sequence, each -> D, Bout, V:
  - A=0100, B=1100 -> D=1000, Bout=1, V=1
  - A=1101, B=0110 -> D=0111, Bout=0, V=1
  - A=1010, B=0101 -> D=0101, Bout=0, V=1
  - A=1000, B=1001 -> D=1111, Bout=1, V=0
- Add mode, A=1001, B=0111 -> D=0000, Bout=1, Z=1, V=0. Then START in FIN cycle with sub, A=0110, B=0110 -> accepted immediately; D=0000, Z=1, Bout=0.
- WIDTH=8, CHUNK=2, sub, A=0x35, B=0x47 -> DONE 4 cycles after START: D=0xEE, Bout=1, V=0. START pulses during BUSY are ignored; DONE fires exactly once.
- WIDTH=8, CHUNK=8: A=0x80, B=0x01 -> DONE after 1 cycle: D=0x7F, Bout=0, V=1.
- RST asserted in 2nd RUN cycle -> next cycle all outputs 0, BUSY=0, no DONE; a subsequent START completes normally.
